// File: rtl/timer_scheduler.sv
// ---------------------------------------------------------------------------
// timer_scheduler
//
// Shares a single external 74163-style up-counter (contador_163) between
// four requesting channels. A round-robin arbiter hands the counter to one
// channel at a time. The counter is preloaded so that it reaches its terminal
// count TEMPO after the channel's requested number of cycles. The counter's
// rco then completes the interval with a one-cycle done pulse.
//
// Ports
//   clock    : single clock, rising edge
//   clr_n    : asynchronous active-low reset
//   req      : per-channel level request; dropping it aborts an owned interval
//   delay    : per-channel delay in cycles, channel i at [i*N +: N]
//   cnt_rco  : ripple carry out from the shared counter
//   cnt_clr  : counter synchronous clear (held while idle)
//   cnt_ld   : counter parallel load
//   cnt_ent  : counter count enable T
//   cnt_enp  : counter count enable P
//   cnt_D    : counter load value
//   gnt      : registered one-hot owner of the counter
//   busy     : an interval is loading or running
//   done     : registered one-cycle one-hot completion pulse
// ---------------------------------------------------------------------------
module timer_scheduler #(
  parameter int N     = 16,
  parameter int TEMPO = 2000
) (
  input  logic           clock,
  input  logic           clr_n,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] delay,
  input  logic           cnt_rco,
  output logic           cnt_clr,
  output logic           cnt_ld,
  output logic           cnt_ent,
  output logic           cnt_enp,
  output logic [N-1:0]   cnt_D,
  output logic [3:0]     gnt,
  output logic           busy,
  output logic [3:0]     done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [N-1:0] TEMPO_N = N'(TEMPO);

  state_e     state_q, state_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [3:0] done_q,  done_d;
  // Last granted channel; while busy it also names the current owner.
  logic [1:0] ptr_q,   ptr_d;

  logic [3:0]   eligible;
  logic [1:0]   win_idx;
  logic [1:0]   cand;
  logic         win_found;
  logic         owner_req;
  logic [N-1:0] sel_delay;

  // -------------------------------------------------------------------------
  // Round-robin search starting one past the last granted channel. A channel
  // that is showing done this cycle may not be regranted on the same edge.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; a path that skips an assignment would otherwise infer a latch.
    eligible  = req & ~done_q;
    win_idx   = ptr_q;
    win_found = 1'b0;
    cand      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req = |(req & gnt_q);
  assign sel_delay = delay[ptr_q*N +: N];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    done_d  = 4'b0000;
    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (win_found) begin
          gnt_d          = 4'b0000;
          gnt_d[win_idx] = 1'b1;
          ptr_d          = win_idx;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        if (!owner_req) begin
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // An abort takes priority over a terminal count on the same edge.
        if (!owner_req) begin
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end else if (cnt_rco) begin
          done_d  = gnt_q;
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      done_q  <= 4'b0000;
      // Pointing at channel 3 makes channel 0 the first candidate.
      ptr_q   <= 2'd3;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Counter controls, decoded from the state alone
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_clr = 1'b0;
    cnt_ld  = 1'b0;
    cnt_ent = 1'b0;
    cnt_enp = 1'b0;
    cnt_D   = '0;
    unique case (state_q)
      IDLE: cnt_clr = 1'b1;
      LOAD: begin
        cnt_ld = 1'b1;
        // Preload so TEMPO is reached after the requested cycles; a delay
        // longer than TEMPO saturates to a full count from zero.
        cnt_D  = (sel_delay > TEMPO_N) ? '0 : (TEMPO_N - sel_delay);
      end
      RUN: begin
        cnt_ent = 1'b1;
        cnt_enp = 1'b1;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q == LOAD) || (state_q == RUN);

endmodule

// File: tb/tb_timer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_timer_scheduler
//
// Drives timer_scheduler with TEMPO=10, N=16. The bench contains a
// behavioural 74163-style counter on the counter control outputs. A
// transaction-level reference model predicts the outputs after every edge.
// It tracks the owner, the grant edge and the saturated delay, and it places
// completion at grant edge + delay + 2. The model pushes predictions into
// queues. Separate monitors pop those queues at the falling edge and compare
// them against the DUT.
// ---------------------------------------------------------------------------
module tb_timer_scheduler;

  localparam int N     = 16;
  localparam int TEMPO = 10;

  logic           clock;
  logic           clr_n;
  logic [3:0]     req;
  logic [4*N-1:0] delay;
  logic           cnt_rco;
  logic           cnt_clr, cnt_ld, cnt_ent, cnt_enp;
  logic [N-1:0]   cnt_D;
  logic [3:0]     gnt;
  logic           busy;
  logic [3:0]     done;

  int n_checks = 0;
  int n_errors = 0;

  timer_scheduler #(.N(N), .TEMPO(TEMPO)) dut (
    .clock   (clock),
    .clr_n   (clr_n),
    .req     (req),
    .delay   (delay),
    .cnt_rco (cnt_rco),
    .cnt_clr (cnt_clr),
    .cnt_ld  (cnt_ld),
    .cnt_ent (cnt_ent),
    .cnt_enp (cnt_enp),
    .cnt_D   (cnt_D),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared up-counter: synchronous clear and load, counts to TEMPO.
  logic [N-1:0] cnt_q;
  always @(posedge clock) begin
    if (cnt_clr)                 cnt_q <= '0;
    else if (cnt_ld)             cnt_q <= cnt_D;
    else if (cnt_ent && cnt_enp) cnt_q <= (cnt_q == N'(TEMPO)) ? '0 : cnt_q + 1'b1;
  end
  assign cnt_rco = cnt_ent && (cnt_q == N'(TEMPO));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic [3:0] done;
    logic       loading;
    int         owner;
  } snap_t;

  snap_t snap_q[$];
  int    done_exp_q[$];

  int         cyc      = 0;
  bit         m_active = 0;
  int         m_owner  = 0;
  int         m_ptr    = 3;
  int         m_grant  = 0;
  int         m_d      = 0;
  logic [3:0] m_done_cur = 4'b0;
  logic [3:0] m_nd;
  logic [3:0] m_elig;
  int         m_w;
  snap_t      m_s;

  function automatic int sat(input int d);
    return (d > TEMPO) ? TEMPO : d;
  endfunction

  always @(posedge clock) begin
    cyc++;
    m_nd = 4'b0;
    if (!clr_n) begin
      m_active   = 0;
      m_ptr      = 3;
      m_done_cur = 4'b0;
    end else begin
      if (m_active) begin
        if (!req[m_owner]) begin
          m_active = 0;
        end else begin
          if (cyc == m_grant + 1) m_d = sat(int'(delay[m_owner*N +: N]));
          if (cyc > m_grant + 1 && cyc == m_grant + m_d + 2) begin
            m_nd[m_owner] = 1'b1;
            m_active      = 0;
            done_exp_q.push_back(m_owner);
          end
        end
      end else begin
        m_elig = req & ~m_done_cur;
        m_w    = -1;
        for (int k = 1; k <= 4; k++)
          if (m_w < 0 && m_elig[(m_ptr + k) % 4]) m_w = (m_ptr + k) % 4;
        if (m_w >= 0) begin
          m_active = 1;
          m_owner  = m_w;
          m_ptr    = m_w;
          m_grant  = cyc;
        end
      end
      m_done_cur = m_nd;
    end
    m_s.gnt     = m_active ? (4'b0001 << m_owner) : 4'b0000;
    m_s.busy    = m_active;
    m_s.done    = m_nd;
    m_s.loading = m_active && (cyc == m_grant);
    m_s.owner   = m_owner;
    snap_q.push_back(m_s);
  end

  // -------------------------------------------------------------------------
  // Monitors
  // -------------------------------------------------------------------------
  snap_t         mon_s;
  logic [28:0]   mon_exp;
  logic [N-1:0]  mon_d;
  int            mon_ch;

  always @(negedge clock) begin
    if (snap_q.size() == 0) begin
      if (clr_n) check("snapshot_queue_empty", 64'd0, 64'd1);
    end else begin
      mon_s = snap_q.pop_front();
      if (clr_n) begin
        if (mon_s.loading) begin
          mon_d   = N'(TEMPO - sat(int'(delay[mon_s.owner*N +: N])));
          mon_exp = {mon_s.gnt, mon_s.busy, mon_s.done, 4'b0100, mon_d};
        end else if (mon_s.busy) begin
          mon_exp = {mon_s.gnt, mon_s.busy, mon_s.done, 4'b0011, 16'd0};
        end else begin
          mon_exp = {mon_s.gnt, mon_s.busy, mon_s.done, 4'b1000, 16'd0};
        end
        check("cycle_outputs",
              64'({gnt, busy, done, cnt_clr, cnt_ld, cnt_ent, cnt_enp, cnt_D}),
              64'(mon_exp));
      end
    end
  end

  always @(negedge clock) begin
    if (clr_n && done != 4'b0000) begin
      if (done_exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_ch = done_exp_q.pop_front();
        check("done_channel", 64'(done), 64'(4'b0001 << mon_ch));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic set_delay(input int ch, input int val);
    delay[ch*N +: N] = N'(val);
  endtask

  task automatic reset_pulse();
    clr_n = 1'b0;
    done_exp_q.delete();
    #1;
    check("async_reset", 64'({gnt, done, busy, cnt_clr}), 64'({4'b0, 4'b0, 1'b0, 1'b1}));
    step(2);
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0;
    req   = 4'b0;
    delay = '0;
    step(3);
    check("reset_state", 64'({gnt, done, busy, cnt_clr, cnt_ld, cnt_ent, cnt_enp}),
          64'({4'b0, 4'b0, 1'b0, 4'b1000}));
    clr_n = 1'b1;

    // Single channel, delay 3.
    set_delay(0, 3);
    req = 4'b0001;
    step(7);
    req = 4'b0000;
    step(4);
    check("counter_idle_zero", 64'(cnt_q), 64'd0);

    // All channels, zero delay: rotating grants.
    for (int i = 0; i < 4; i++) set_delay(i, 0);
    req = 4'b1111;
    step(20);
    req = 4'b0000;
    step(3);

    // Saturated delay.
    set_delay(1, 25);
    req = 4'b0010;
    step(14);
    req = 4'b0000;
    step(3);

    // Abort during the run; the other requester follows.
    set_delay(0, 5);
    set_delay(1, 1);
    req = 4'b0011;
    step(3);
    req = 4'b0010;
    step(12);
    req = 4'b0000;
    step(3);

    // Reset in the middle of a run, then a fresh grant from channel 0 upward.
    set_delay(0, 8);
    req = 4'b0001;
    step(5);
    reset_pulse();
    req = 4'b0100;
    step(1);
    check("grant_after_reset", 64'(gnt), 64'(4'b0100));
    step(14);
    req = 4'b0000;
    step(3);

    // Abort on the same edge as the terminal count.
    set_delay(0, 2);
    req = 4'b0001;
    step(4);
    req = 4'b0000;
    step(1);
    check("abort_beats_rco", 64'({done, busy}), 64'd0);
    step(3);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        int ch;
        ch = int'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) set_delay(ch, int'($urandom_range(0, 30)));
        else                           set_delay(ch, int'($urandom_range(0, 6)));
      end
      if ($urandom_range(0, 149) == 0) reset_pulse();
      else                             step(1);
    end

    req = 4'b0000;
    step(20);
    check("done_queue_drained", 64'(done_exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
